// File: rtl/delay_pkg.sv
// Shared helpers for the variable delay line.
// Holds the delay-select clamp used to keep the tap index inside the stage array.
// Stage storage types depend on WIDTH, so they live in the module that uses them.
package delay_pkg;

    // Requested tap index, clamped to the last physical stage. Out-of-range
    // requests can only occur when MAX_DEL is not a power of two.
    function automatic int unsigned del_clamp(input int unsigned sel,
                                              input int unsigned max_del);
        return (sel >= max_del) ? (max_del - 1) : sel;
    endfunction

endpackage

// File: rtl/delay_tap_mux.sv
// Output tap select: picks one stage (data + valid) out of the stage array.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; follows the select and stage registers directly.
//
// Ports:
//   i_dat  stage data, index 0 is the newest sample
//   i_vld  stage valids, aligned with i_dat
//   i_sel  stage index to expose
//   o_dat  selected data
//   o_vld  selected valid
module delay_tap_mux #(
    parameter int WIDTH   = 8,
    parameter int MAX_DEL = 16,
    parameter int DW      = 4
) (
    input  logic [MAX_DEL-1:0][WIDTH-1:0] i_dat,
    input  logic [MAX_DEL-1:0]            i_vld,
    input  logic [DW-1:0]                 i_sel,
    output logic [WIDTH-1:0]              o_dat,
    output logic                          o_vld
);

    // Compare-based select keeps indices that have no stage behind them
    // (non power-of-two MAX_DEL) defined as zero.
    always_comb begin
        o_dat = '0;
        o_vld = 1'b0;
        for (int i = 0; i < MAX_DEL; i++) begin
            if (i_sel == DW'(i)) begin
                o_dat = i_dat[i];
                o_vld = i_vld[i];
            end
        end
    end

endmodule

// File: rtl/delay_var.sv
// Runtime-programmable, stallable delay line (1..MAX_DEL cycles) with valid, flush and settle mask.
// Latency: cur_sel+1 enabled clock edges from din to dout; stall (en=0) cycles add one-for-one.
// Backpressure: none; en=0 freezes the whole block, outputs held stable.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   en                  advance enable (0 = stall)
//   flush               synchronous clear of stages, applies new delay immediately
//   del_sel             requested delay minus one, clamped to MAX_DEL-1
//   din_valid, din      input sample
//   dout_valid, dout    delayed sample; valid masked while settling
//   settling            high while a delay change is settling
module delay_var
    import delay_pkg::*;
#(
    parameter  int WIDTH   = 8,
    parameter  int MAX_DEL = 16,
    localparam int DW      = $clog2(MAX_DEL)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             flush,
    input  logic [DW-1:0]    del_sel,
    input  logic             din_valid,
    input  logic [WIDTH-1:0] din,
    output logic             dout_valid,
    output logic [WIDTH-1:0] dout,
    output logic             settling
);

    typedef struct packed {
        logic             v;
        logic [WIDTH-1:0] d;
    } stage_t;

    logic [DW-1:0]                 r_cur_sel;
    logic [DW:0]                   r_settle_cnt;
    logic [DW-1:0]                 w_sel_clamp;
    logic [MAX_DEL-1:0][WIDTH-1:0] w_stage_dat;
    logic [MAX_DEL-1:0]            w_stage_vld;
    logic [WIDTH-1:0]              w_tap_dat;
    logic                          w_tap_vld;

    assign w_sel_clamp = DW'(del_clamp(32'(del_sel), 32'(MAX_DEL)));

    // Every stage shifts on en, including those past the active tap, so a
    // longer delay later exposes genuine history once settling completes.
    for (genvar g = 0; g < MAX_DEL; g++) begin : g_stage
        stage_t r_q;
        stage_t w_in;

        if (g == 0) begin : g_head
            assign w_in = '{v: din_valid, d: din};
        end else begin : g_body
            assign w_in = '{v: w_stage_vld[g-1], d: w_stage_dat[g-1]};
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_q <= '0;
            end else if (flush) begin
                r_q <= '0;
            end else if (en) begin
                r_q <= w_in;
            end
        end

        assign w_stage_dat[g] = r_q.d;
        assign w_stage_vld[g] = r_q.v;
    end

    // A new tap index needs clamp+1 enabled edges before the stages behind it
    // all hold samples taken under the new alignment; the counter masks valid
    // until then. Flush empties the line, so no masking is needed after it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cur_sel    <= '0;
            r_settle_cnt <= '0;
        end else if (flush) begin
            r_cur_sel    <= w_sel_clamp;
            r_settle_cnt <= '0;
        end else if (en) begin
            if (w_sel_clamp != r_cur_sel) begin
                r_cur_sel    <= w_sel_clamp;
                r_settle_cnt <= {1'b0, w_sel_clamp} + (DW+1)'(1);
            end else if (r_settle_cnt != '0) begin
                r_settle_cnt <= r_settle_cnt - (DW+1)'(1);
            end
        end
    end

    delay_tap_mux #(
        .WIDTH   (WIDTH),
        .MAX_DEL (MAX_DEL),
        .DW      (DW)
    ) u_tap_mux (
        .i_dat (w_stage_dat),
        .i_vld (w_stage_vld),
        .i_sel (r_cur_sel),
        .o_dat (w_tap_dat),
        .o_vld (w_tap_vld)
    );

    assign dout       = w_tap_dat;
    assign dout_valid = w_tap_vld && (r_settle_cnt == '0);
    assign settling   = (r_settle_cnt != '0);

endmodule

// File: tb/tb_delay_var.sv
// Self-checking bench for delay_var (MAX_DEL=12 to exercise the clamp).
// Reference: a log of samples accepted since the last clear; expected output
// is the sample accepted cur_sel+1 enabled edges ago.
module tb_delay_var;

    localparam int WIDTH   = 8;
    localparam int MAX_DEL = 12;
    localparam int DW      = $clog2(MAX_DEL);

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             flush;
    logic [DW-1:0]    del_sel;
    logic             din_valid;
    logic [WIDTH-1:0] din;
    logic             dout_valid;
    logic [WIDTH-1:0] dout;
    logic             settling;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [WIDTH:0] m_log [$];   // {valid, data}, newest at the back
    int             m_sel = 0;   // delay in effect minus one
    int             m_settle = 0; // enabled edges left before output is trusted

    delay_var #(
        .WIDTH   (WIDTH),
        .MAX_DEL (MAX_DEL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .flush      (flush),
        .del_sel    (del_sel),
        .din_valid  (din_valid),
        .din        (din),
        .dout_valid (dout_valid),
        .dout       (dout),
        .settling   (settling)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int req_delay(input int sel);
        return (sel > MAX_DEL - 1) ? MAX_DEL - 1 : sel;
    endfunction

    // Apply the inputs present at the edge just taken to the model.
    task automatic model_edge();
        int want;
        want = req_delay(int'(del_sel));
        if (!rst_n) begin
            m_log.delete();
            m_sel    = 0;
            m_settle = 0;
        end else if (flush) begin
            m_log.delete();
            m_sel    = want;
            m_settle = 0;
        end else if (en) begin
            m_log.push_back({din_valid, din});
            if (m_log.size() > 64) void'(m_log.pop_front());
            if (want != m_sel) begin
                m_sel    = want;
                m_settle = want + 1;
            end else if (m_settle > 0) begin
                m_settle--;
            end
        end
    endtask

    task automatic model_check();
        logic [WIDTH:0] s;
        s = '0;
        if (m_log.size() > m_sel) s = m_log[m_log.size() - 1 - m_sel];
        chk("dout",     32'(dout),       32'(s[WIDTH-1:0]));
        chk("dout_vld", 32'(dout_valid), 32'(s[WIDTH] && (m_settle == 0)));
        chk("settling", 32'(settling),   32'(m_settle != 0));
    endtask

    // One clock: edge consumes current inputs, outputs compared mid-cycle.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        model_check();
    endtask

    initial begin
        logic [WIDTH-1:0] d_hold;
        logic             v_hold;
        int               k;
        int               cnt;

        rst_n = 1'b0; en = 1'b1; flush = 1'b0; del_sel = '0;
        din_valid = 1'b1; din = 8'hAA;

        // Reset held with active input
        repeat (3) cycle();
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_vld",  32'(dout_valid), 32'h0);
        chk("rst_set",  32'(settling), 32'h0);

        // Fixed delay of 4 edges, continuous ramp
        rst_n = 1'b1; del_sel = 4'd3;
        k = 0;
        for (int i = 0; i < 12; i++) begin
            k++; din = 8'(k); cycle();
            if (k >= 5) chk("lat4", 32'(dout), 32'(k - 3));
        end
        chk("lat4_vld", 32'(dout_valid), 32'h1);

        // Stall: outputs frozen while din wanders
        d_hold = dout; v_hold = dout_valid; en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            din = 8'($urandom_range(0, 255)); cycle();
            chk("stall_d", 32'(dout), 32'(d_hold));
            chk("stall_v", 32'(dout_valid), 32'(v_hold));
        end
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            k++; din = 8'(k); cycle();
            chk("resume", 32'(dout), 32'(k - 3));
        end

        // Lengthen 4 -> 8 edges
        del_sel = 4'd7; cnt = 0;
        for (int i = 0; i < 12; i++) begin
            k++; din = 8'(k); cycle();
            if (settling) cnt++;
        end
        chk("settle_len", 32'(cnt), 32'd8);
        chk("lat8",       32'(dout), 32'(k - 7));
        chk("lat8_vld",   32'(dout_valid), 32'h1);

        // Flush together with a pending delay change
        del_sel = 4'd5; flush = 1'b1;
        k++; din = 8'(k); cycle();
        chk("flush_vld", 32'(dout_valid), 32'h0);
        chk("flush_set", 32'(settling), 32'h0);
        chk("flush_d",   32'(dout), 32'h0);
        flush = 1'b0;
        for (int j = 0; j < 8; j++) begin
            din = 8'(100 + j); cycle();
            if (j == 4) chk("flush_early", 32'(dout_valid), 32'h0);
            if (j == 5) chk("flush_first", 32'(dout), 32'd100);
        end

        // Out-of-range select clamps to the last stage
        del_sel = 4'd15; k = 200;
        for (int i = 0; i < 20; i++) begin
            k++; din = 8'(k); cycle();
        end
        chk("clamp_d",   32'(dout), 32'(k - 11));
        chk("clamp_vld", 32'(dout_valid), 32'h1);

        // Reset mid-stream: nothing from before reset may surface
        rst_n = 1'b0; cycle();
        rst_n = 1'b1; din_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            din = 8'($urandom_range(0, 255)); cycle();
            chk("rst_novld", 32'(dout_valid), 32'h0);
        end

        // Randomised traffic against the model
        for (int i = 0; i < 600; i++) begin
            en        = ($urandom_range(0, 99) < 80);
            flush     = ($urandom_range(0, 99) < 3);
            rst_n     = ($urandom_range(0, 199) != 0);
            din_valid = ($urandom_range(0, 99) < 70);
            din       = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 99) < 6) del_sel = DW'($urandom_range(0, 15));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
